// File: rtl/ball_motion_controller_if.sv
// Ball controller bus: VGA counters, serve and paddle inputs in; ball box,
// score pulses and FSM state out.
interface ball_motion_controller_if;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       serve;
  logic [9:0] l_paddle_y;
  logic [9:0] r_paddle_y;
  logic [9:0] ball_h_lower;
  logic [9:0] ball_h_upper;
  logic [9:0] ball_v_lower;
  logic [9:0] ball_v_upper;
  logic       score_left;
  logic       score_right;
  logic [1:0] state;

  // Driver of counters and player inputs (timing block / game logic)
  modport master (
    output h_count, v_count, serve, l_paddle_y, r_paddle_y,
    input  ball_h_lower, ball_h_upper, ball_v_lower, ball_v_upper,
    input  score_left, score_right, state
  );

  // The ball controller itself
  modport slave (
    input  h_count, v_count, serve, l_paddle_y, r_paddle_y,
    output ball_h_lower, ball_h_upper, ball_v_lower, ball_v_upper,
    output score_left, score_right, state
  );
endinterface

// File: rtl/ball_motion_controller.sv
// Pong ball controller: steps the ball once per frame, bounces off walls and
// paddles, detects misses and pulses the score of the player who won the point.
module ball_motion_controller #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int STEP        = 2,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 64,
  parameter int L_PADDLE_X  = 16,
  parameter int R_PADDLE_X  = 616,
  parameter int SERVE_DELAY = 60
) (
  input logic                      clk,
  input logic                      rst_n,
  ball_motion_controller_if.slave  bus
);

  // 11-bit compare constants so that sums of 10-bit coordinates never wrap
  localparam logic [10:0] C_H    = 11'(H_ACTIVE);
  localparam logic [10:0] C_V    = 11'(V_ACTIVE);
  localparam logic [10:0] C_B    = 11'(BALL_SIZE);
  localparam logic [10:0] C_S    = 11'(STEP);
  localparam logic [10:0] C_LF   = 11'(L_PADDLE_X + PADDLE_W);
  localparam logic [10:0] C_RF   = 11'(R_PADDLE_X);
  localparam logic [10:0] C_PH   = 11'(PADDLE_H);

  localparam logic [9:0]  X_CTR  = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_CTR  = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  X_LHIT = 10'(L_PADDLE_X + PADDLE_W);
  localparam logic [9:0]  X_RHIT = 10'(R_PADDLE_X - BALL_SIZE);
  localparam logic [9:0]  Y_BOT  = 10'(V_ACTIVE - BALL_SIZE);

  localparam int          CNT_W   = $clog2(SERVE_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_MOVE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [9:0]         r_x;
  logic [9:0]         r_y;
  logic               r_dx_pos;
  logic               r_dy_pos;
  logic               r_score_left;
  logic               r_score_right;
  logic               r_frame_cond_d;

  logic               w_frame_cond;
  logic               w_frame_tick;
  logic [10:0]        w_x11;
  logic [10:0]        w_y11;
  logic [10:0]        w_lp11;
  logic [10:0]        w_rp11;
  logic               w_l_ov;
  logic               w_r_ov;
  logic [9:0]         w_x_nxt;
  logic [9:0]         w_y_nxt;
  logic               w_dx_nxt;
  logic               w_dy_nxt;
  logic               w_miss_l;
  logic               w_miss_r;
  logic               w_move;
  logic               w_miss;
  logic               w_cnt_clr;
  logic               w_cnt_inc;

  // Frame tick: rising edge of the first blanking position, however long it holds
  assign w_frame_cond = (bus.v_count == 10'(V_ACTIVE)) && (bus.h_count == 10'd0);
  assign w_frame_tick = w_frame_cond & ~r_frame_cond_d;

  // Delay register for the frame-tick edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_cond_d <= 1'b0;
    else        r_frame_cond_d <= w_frame_cond;
  end

  assign w_x11  = {1'b0, r_x};
  assign w_y11  = {1'b0, r_y};
  assign w_lp11 = {1'b0, bus.l_paddle_y};
  assign w_rp11 = {1'b0, bus.r_paddle_y};
  assign w_l_ov = (w_y11 + C_B > w_lp11) && (w_y11 < w_lp11 + C_PH);
  assign w_r_ov = (w_y11 + C_B > w_rp11) && (w_y11 < w_rp11 + C_PH);

  // Horizontal rule: paddle face bounce, miss past the edge, or plain step
  always_comb begin
    w_x_nxt  = r_x;
    w_dx_nxt = r_dx_pos;
    w_miss_l = 1'b0;
    w_miss_r = 1'b0;
    if (!r_dx_pos) begin
      if ((w_x11 >= C_LF) && (w_x11 - C_S < C_LF) && w_l_ov) begin
        w_x_nxt  = X_LHIT;
        w_dx_nxt = 1'b1;
      end else if (w_x11 < C_S) begin
        w_miss_l = 1'b1;
      end else begin
        w_x_nxt  = 10'(w_x11 - C_S);
      end
    end else begin
      if ((w_x11 + C_B <= C_RF) && (w_x11 + C_S + C_B > C_RF) && w_r_ov) begin
        w_x_nxt  = X_RHIT;
        w_dx_nxt = 1'b0;
      end else if (w_x11 + C_S + C_B > C_H) begin
        w_miss_r = 1'b1;
      end else begin
        w_x_nxt  = 10'(w_x11 + C_S);
      end
    end
  end

  // Vertical rule: clamp to the wall and reverse, otherwise plain step
  always_comb begin
    w_y_nxt  = r_y;
    w_dy_nxt = r_dy_pos;
    if (!r_dy_pos) begin
      if (w_y11 < C_S) begin
        w_y_nxt  = 10'd0;
        w_dy_nxt = 1'b1;
      end else begin
        w_y_nxt  = 10'(w_y11 - C_S);
      end
    end else begin
      if (w_y11 + C_S + C_B > C_V) begin
        w_y_nxt  = Y_BOT;
        w_dy_nxt = 1'b0;
      end else begin
        w_y_nxt  = 10'(w_y11 + C_S);
      end
    end
  end

  // FSM state register, advanced only on frame ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_state <= S_IDLE;
    else if (w_frame_tick) r_state <= w_state_nxt;
  end

  // FSM next state: serve starts the delay, delay expiry starts play, a miss re-serves
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.serve)              w_state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == CNT_LAST)      w_state_nxt = S_MOVE;
      S_MOVE:  if (w_miss_l || w_miss_r)   w_state_nxt = S_WAIT;
      default:                             w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: per-tick enables for the serve counter and ball datapath
  always_comb begin
    w_move    = w_frame_tick && (r_state == S_MOVE);
    w_miss    = w_move && (w_miss_l || w_miss_r);
    w_cnt_inc = w_frame_tick && (r_state == S_WAIT);
    w_cnt_clr = w_frame_tick && (w_state_nxt == S_WAIT) && (r_state != S_WAIT);
  end

  // Serve-delay counter, restarted on every entry to SERVE_WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_cnt <= '0;
    else if (w_cnt_clr) r_cnt <= '0;
    else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
  end

  // Ball position and direction; a miss recentres with dx kept toward the loser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= X_CTR;
      r_y      <= Y_CTR;
      r_dx_pos <= 1'b1;
      r_dy_pos <= 1'b1;
    end else if (w_move) begin
      r_x      <= w_miss ? X_CTR : w_x_nxt;
      r_y      <= w_miss ? Y_CTR : w_y_nxt;
      r_dx_pos <= w_dx_nxt;
      r_dy_pos <= w_dy_nxt;
    end
  end

  // Score pulses, high for the single clock after the missing tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score_left  <= 1'b0;
      r_score_right <= 1'b0;
    end else begin
      r_score_left  <= w_move && w_miss_r;
      r_score_right <= w_move && w_miss_l;
    end
  end

  assign bus.ball_h_lower = r_x;
  assign bus.ball_h_upper = 10'(w_x11 + C_B);
  assign bus.ball_v_lower = r_y;
  assign bus.ball_v_upper = 10'(w_y11 + C_B);
  assign bus.score_left   = r_score_left;
  assign bus.score_right  = r_score_right;
  assign bus.state        = r_state;

endmodule

// File: tb/tb_ball_motion_controller.sv
// Randomised bench for ball_motion_controller with a queue-based scoreboard
// and an integer reference model of the Pong ball rules.
module tb_ball_motion_controller;
  localparam int SD   = 2;
  localparam int HA   = 640;
  localparam int VA   = 480;
  localparam int BS   = 8;
  localparam int ST   = 2;
  localparam int PH   = 64;
  localparam int LFACE = 24;   // left paddle x + width
  localparam int RFACE = 616;  // right paddle x

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ball_motion_controller_if bus();

  ball_motion_controller #(.SERVE_DELAY(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [9:0] hl;
    logic [9:0] hu;
    logic [9:0] vl;
    logic [9:0] vu;
    logic [1:0] st;
    logic       sl;
    logic       sr;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_checks = 0;
  int   n_pass   = 0;

  // reference model state
  int mx, my, mdx, mdy, mmode, mcnt;

  function automatic string fmt(exp_t e);
    return $sformatf("h=%0d..%0d v=%0d..%0d st=%0d sl=%0d sr=%0d",
                     e.hl, e.hu, e.vl, e.vu, e.st, e.sl, e.sr);
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.hl = 10'd316; e.hu = 10'd324; e.vl = 10'd236; e.vu = 10'd244;
    e.st = 2'd0; e.sl = 1'b0; e.sr = 1'b0;
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t e;
    e.hl = bus.ball_h_lower; e.hu = bus.ball_h_upper;
    e.vl = bus.ball_v_lower; e.vu = bus.ball_v_upper;
    e.st = bus.state; e.sl = bus.score_left; e.sr = bus.score_right;
    return e;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s @%0t: got %s, want %s", name, $time, fmt(got), fmt(want));
  endtask

  task automatic model_reset();
    mx = (HA - BS) / 2; my = (VA - BS) / 2;
    mdx = 1; mdy = 1; mmode = 0; mcnt = 0;
  endtask

  // One frame of game rules, computed with signed integer arithmetic
  task automatic model_tick(input bit serve, input int lp, input int rp);
    exp_t e;
    int nx, ny, ndx, ndy;
    bit ml, mr;
    ml = 0; mr = 0;
    case (mmode)
      0: if (serve) begin mmode = 1; mcnt = 0; end
      1: if (mcnt == SD - 1) mmode = 2; else mcnt++;
      default: begin
        ny = my + ST * mdy; ndy = mdy;
        if (mdy < 0 && my < ST) begin ny = 0; ndy = 1; end
        else if (mdy > 0 && my + ST + BS > VA) begin ny = VA - BS; ndy = -1; end
        nx = mx + ST * mdx; ndx = mdx;
        if (mdx < 0) begin
          if (mx >= LFACE && mx - ST < LFACE && my + BS > lp && my < lp + PH) begin
            nx = LFACE; ndx = 1;
          end else if (mx < ST) ml = 1;
        end else begin
          if (mx + BS <= RFACE && mx + ST + BS > RFACE && my + BS > rp && my < rp + PH) begin
            nx = RFACE - BS; ndx = -1;
          end else if (mx + ST + BS > HA) mr = 1;
        end
        if (ml || mr) begin
          nx = (HA - BS) / 2; ny = (VA - BS) / 2; mmode = 1; mcnt = 0;
        end
        mx = nx; my = ny; mdx = ndx; mdy = ndy;
      end
    endcase
    e.hl = 10'(mx); e.hu = 10'(mx + BS); e.vl = 10'(my); e.vu = 10'(my + BS);
    e.st = 2'(mmode); e.sl = mr; e.sr = ml;
    q.push_back(e);
  endtask

  // Monitor: track frame-tick edges seen on the bus
  logic m_cond, m_prev, m_tick;
  assign m_cond = (bus.v_count == 10'd480) && (bus.h_count == 10'd0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev <= 1'b0;
      m_tick <= 1'b0;
    end else begin
      m_tick <= m_cond && !m_prev;
      m_prev <= m_cond;
    end
  end

  // Monitor: pop expected after each tick, otherwise outputs must hold steady
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("reset_state", dut_out(), reset_exp());
      last = reset_exp();
    end else if (m_tick) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL tick_unexpected @%0t: got %s, want no update", $time, fmt(dut_out()));
      end else begin
        e = q.pop_front();
        check("frame_update", dut_out(), e);
        last = e;
        last.sl = 1'b0;
        last.sr = 1'b0;
      end
    end else begin
      check("hold_stable", dut_out(), last);
    end
  end

  // Asynchronous reset must take effect before any clock edge
  always @(negedge rst_n) begin
    #1;
    check("async_reset", dut_out(), reset_exp());
  end

  task automatic set_idle_counts();
    logic [9:0] v, h;
    v = 10'($urandom_range(0, 524));
    h = 10'($urandom_range(0, 799));
    if (v == 10'd480 && h == 10'd0) h = 10'd1;
    bus.v_count = v;
    bus.h_count = h;
  endtask

  function automatic logic [9:0] pick_paddle(input int y);
    int t;
    if ($urandom_range(0, 4) == 0) return 10'($urandom_range(0, VA - PH));
    t = y + BS - int'($urandom_range(0, PH + BS));
    if (t < 0) t = 0;
    return 10'(t);
  endfunction

  initial begin
    logic s;
    logic [9:0] lp, rp;
    rst_n = 1'b0;
    bus.h_count = 10'd0; bus.v_count = 10'd0; bus.serve = 1'b0;
    bus.l_paddle_y = 10'd0; bus.r_paddle_y = 10'd0;
    model_reset();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    for (int f = 0; f < 1500; f++) begin
      @(negedge clk);
      if (mmode == 0) s = ($urandom_range(0, 2) == 0);
      else            s = 1'($urandom_range(0, 1));
      lp = pick_paddle(my);
      rp = pick_paddle(my);
      bus.serve = s; bus.l_paddle_y = lp; bus.r_paddle_y = rp;
      bus.v_count = 10'd480; bus.h_count = 10'd0;
      model_tick(s, int'(lp), int'(rp));
      // long hold of the tick position must still give one update
      repeat ((f == 300) ? 50 : $urandom_range(1, 3)) begin
        @(negedge clk);
        bus.serve = 1'($urandom_range(0, 1));
        bus.l_paddle_y = 10'($urandom_range(0, 1023));
        bus.r_paddle_y = 10'($urandom_range(0, 1023));
      end
      set_idle_counts();
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        set_idle_counts();
      end
      if (f == 600 || f == 1100) begin
        #2 rst_n = 1'b0;
        model_reset();
        q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end

    repeat (4) @(negedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case the stimulus never completes
  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, want finish");
    $fatal(1, "timeout");
  end
endmodule
